myriadrf_cfg_regs: RTL



---
 rtl/myriadrf_cfg_pkg.sv | 29 ++
 rtl/myriadrf_cfg_status.sv | 56 +++++
 rtl/myriadrf_cfg_regs.sv | 139 +++++++++++++
 3 files changed

// File: rtl/myriadrf_cfg_pkg.sv
// Register map, control-bit positions and Wishbone cycle encodings for myriadrf_cfg_regs.
package myriadrf_cfg_pkg;

  localparam int unsigned IDX_W      = 6;
  localparam int unsigned CH_BITS    = 4;
  localparam int unsigned STS_TX_LSB = 8;

  localparam logic [IDX_W-1:0] REG_ID      = 6'd0;
  localparam logic [IDX_W-1:0] REG_GCTRL   = 6'd1;
  localparam logic [IDX_W-1:0] REG_STROBE  = 6'd2;
  localparam logic [IDX_W-1:0] REG_STATUS  = 6'd3;
  localparam logic [IDX_W-1:0] REG_IRQMASK = 6'd4;
  localparam logic [IDX_W-1:0] REG_CH_BASE = 6'd8;

  localparam int unsigned CH_TX_SRC  = 0;
  localparam int unsigned CH_RX_SRC  = 1;
  localparam int unsigned CH_RX_SINK = 2;
  localparam int unsigned CH_EN      = 3;

  localparam int unsigned GCTRL_LOOPBACK = 0;
  localparam int unsigned GCTRL_SPI_SEL  = 1;
  localparam int unsigned GCTRL_W        = 2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/myriadrf_cfg_status.sv
// Sticky write-1-to-clear event status, interrupt mask and registered level interrupt.
module myriadrf_cfg_status
  import myriadrf_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] rx_ovf,
  input  logic [NUM_CH-1:0] tx_unf,
  input  logic              sts_we,
  input  logic              msk_we,
  input  logic [15:0]       wbits,
  input  logic [15:0]       wmask,
  output logic [15:0]       sts_word,
  output logic [15:0]       msk_word,
  output logic              irq
);

  logic [NUM_CH-1:0] rx_sts, tx_sts, rx_msk, tx_msk, rx_clr, tx_clr;
  logic              unused_ok;

  assign rx_clr = sts_we ? wbits[NUM_CH-1:0] : '0;
  assign tx_clr = sts_we ? wbits[STS_TX_LSB +: NUM_CH] : '0;

  // Event OR-ed in after the clear, so a same-cycle event beats a W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sts <= '0;
      tx_sts <= '0;
      rx_msk <= '0;
      tx_msk <= '0;
      irq    <= 1'b0;
    end else begin
      rx_sts <= (rx_sts & ~rx_clr) | rx_ovf;
      tx_sts <= (tx_sts & ~tx_clr) | tx_unf;
      if (msk_we) begin
        rx_msk <= (rx_msk & ~wmask[NUM_CH-1:0]) | wbits[NUM_CH-1:0];
        tx_msk <= (tx_msk & ~wmask[STS_TX_LSB +: NUM_CH]) | wbits[STS_TX_LSB +: NUM_CH];
      end
      irq <= |{rx_sts & rx_msk, tx_sts & tx_msk};
    end
  end

  always_comb begin
    sts_word = '0;
    msk_word = '0;
    sts_word[NUM_CH-1:0]              = rx_sts;
    sts_word[STS_TX_LSB +: NUM_CH]    = tx_sts;
    msk_word[NUM_CH-1:0]              = rx_msk;
    msk_word[STS_TX_LSB +: NUM_CH]    = tx_msk;
  end

  assign unused_ok = &{1'b0, wbits, wmask};

endmodule

// File: rtl/myriadrf_cfg_regs.sv
// Wishbone B3 configuration slave for the MyriadRF interface (classic + linear burst).
// Build option: define MYRIADRF_CFG_ERR_EN to answer unmapped accesses with wb_err_o.
module myriadrf_cfg_regs
  import myriadrf_cfg_pkg::*;
#(
  parameter int unsigned WB_AW   = 32,
  parameter int unsigned WB_DW   = 32,
  parameter int unsigned NUM_CH  = 2,
  parameter logic [15:0] VERSION = 16'h0200
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic [WB_DW/8-1:0] wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic [NUM_CH-1:0]  ch_tx_src_o,
  output logic [NUM_CH-1:0]  ch_rx_src_o,
  output logic [NUM_CH-1:0]  ch_rx_sink_o,
  output logic [NUM_CH-1:0]  ch_en_o,
  output logic               loopback_o,
  output logic               spi_sel_o,
  output logic               soft_rst_o,
  input  logic [NUM_CH-1:0]  rx_ovf_i,
  input  logic [NUM_CH-1:0]  tx_unf_i,
  output logic               irq_o
);

  localparam int unsigned SEL_W = WB_DW / 8;

  logic [IDX_W-1:0]   adr_idx, rd_idx, beat_cnt;
  logic               ack_q, err_q, ack_nxt, err_nxt;
  logic               burst_cur, cont, launch, wr_beat;
  logic [WB_DW-1:0]   bmask, wbits, rd_data;
  logic [GCTRL_W-1:0] gctrl;
  logic [CH_BITS-1:0] ch_ctrl [NUM_CH];
  logic [15:0]        sts_word, msk_word;
  logic               soft_rst, unused_ok;

  assign adr_idx   = wb_adr_i[7:2];
  assign burst_cur = (wb_cti_i == CTI_INCR) && (wb_bte_i == BTE_LINEAR);
  // An acked non-final linear beat is followed back-to-back by the next one
  assign cont      = ack_q && burst_cur;
  assign launch    = wb_cyc_i && wb_stb_i && (cont || !(ack_q || err_q));
  assign rd_idx    = cont ? beat_cnt : adr_idx;
  assign wr_beat   = wb_cyc_i && wb_stb_i && wb_we_i && ack_q;

`ifdef MYRIADRF_CFG_ERR_EN
  function automatic logic idx_mapped(input logic [IDX_W-1:0] idx);
    return (idx <= REG_IRQMASK) ||
           ((idx >= REG_CH_BASE) && (idx < REG_CH_BASE + IDX_W'(NUM_CH)));
  endfunction

  assign ack_nxt = launch && idx_mapped(rd_idx);
  assign err_nxt = launch && !idx_mapped(rd_idx);
`else
  assign ack_nxt = launch;
  assign err_nxt = 1'b0;
`endif

  always_comb begin
    bmask = '0;
    for (int i = 0; i < SEL_W; i++) bmask[i*8 +: 8] = {8{wb_sel_i[i]}};
  end
  assign wbits = wb_dat_i & bmask;

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      REG_ID:      rd_data = WB_DW'({8'h00, 8'(NUM_CH), VERSION});
      REG_GCTRL:   rd_data = WB_DW'(gctrl);
      REG_STATUS:  rd_data = WB_DW'(sts_word);
      REG_IRQMASK: rd_data = WB_DW'(msk_word);
      default:     rd_data = '0;
    endcase
    for (int c = 0; c < NUM_CH; c++)
      if (rd_idx == REG_CH_BASE + IDX_W'(c)) rd_data = WB_DW'(ch_ctrl[c]);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
      wb_dat_o <= '0;
      gctrl    <= '0;
      soft_rst <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) ch_ctrl[c] <= '0;
    end else begin
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
      wb_dat_o <= ack_nxt ? rd_data : '0;
      if (launch) beat_cnt <= rd_idx + IDX_W'(1);
      soft_rst <= wr_beat && (adr_idx == REG_STROBE) && wbits[0];
      if (wr_beat && (adr_idx == REG_GCTRL) && wb_sel_i[0]) gctrl <= wbits[GCTRL_W-1:0];
      for (int c = 0; c < NUM_CH; c++)
        if (wr_beat && wb_sel_i[0] && (adr_idx == REG_CH_BASE + IDX_W'(c)))
          ch_ctrl[c] <= wbits[CH_BITS-1:0];
    end
  end

  myriadrf_cfg_status #(.NUM_CH(NUM_CH)) u_status (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .rx_ovf   (rx_ovf_i),
    .tx_unf   (tx_unf_i),
    .sts_we   (wr_beat && (adr_idx == REG_STATUS)),
    .msk_we   (wr_beat && (adr_idx == REG_IRQMASK)),
    .wbits    (wbits[15:0]),
    .wmask    (bmask[15:0]),
    .sts_word (sts_word),
    .msk_word (msk_word),
    .irq      (irq_o)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_tx_src_o[c]  = ch_ctrl[c][CH_TX_SRC];
    assign ch_rx_src_o[c]  = ch_ctrl[c][CH_RX_SRC];
    assign ch_rx_sink_o[c] = ch_ctrl[c][CH_RX_SINK];
    assign ch_en_o[c]      = ch_ctrl[c][CH_EN];
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign loopback_o = gctrl[GCTRL_LOOPBACK];
  assign spi_sel_o  = gctrl[GCTRL_SPI_SEL];
  assign soft_rst_o = soft_rst;
  assign unused_ok  = &{1'b0, wb_adr_i, wbits, bmask};

endmodule
